// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the per-TX-port round-robin arbiter
//
// Purpose: holds the arbiter state encoding and the modular index increment
// used when advancing the round-robin pointer past the port just served.
// Contents:
//   arb_state_t : IDLE / BUSY / DONE / RELEASE, 2 bits
//   next_idx()  : (idx + 1) mod ports
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Written as a compare rather than '%' so it maps to an incrementer and a mux.
  function automatic int next_idx(input int idx, input int ports);
    return (idx + 1 >= ports) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
//
// Purpose: finds the first set request bit searching upward from ptr,
// wrapping from PORTS-1 back to 0.
// Ports:
//   reqs   in  PORTS      request vector
//   ptr    in  PORT_BITS  search start index, always < PORTS
//   any    out 1          at least one request bit is set
//   winner out PORT_BITS  index of the chosen request (0 when any=0)
module rr_pick #(
  parameter int PORTS     = 5,
  parameter int PORT_BITS = 8
) (
  input  logic [PORTS-1:0]     reqs,
  input  logic [PORT_BITS-1:0] ptr,
  output logic                 any,
  output logic [PORT_BITS-1:0] winner
);

  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int k = 0; k < PORTS; k++) begin
      int               idx;
      logic [PORTS-1:0] rot;
      idx = (int'(ptr) + k) % PORTS;
      rot = reqs >> idx;
      // Only the first hit in search order may claim the grant.
      if (!any && rot[0]) begin
        any    = 1'b1;
        winner = PORT_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// rtl/rr_port_arbiter.sv - per-TX-port round-robin switch arbiter with req/ack relay
//
// Purpose: grants one RX requester per packet in round-robin order, relays the
// four-phase req/ack handshake between that RX port and the TX port, and drives
// the select index that steers the router data/address muxes.
// Ports:
//   clk      in  1          rising-edge clock
//   reset    in  1          synchronous, active-high
//   reqs_in  in  PORTS      bit j: RX j requests this TX port
//   acks_in  out PORTS      bit j: acknowledge to RX j (only bit [selected] may be set)
//   req_out  out 1          request to the TX port
//   ack_out  in  1          TX port reports packet transfer complete
//   selected out PORT_BITS  granted RX index, zero-extended
//   active   out 1          grant held, selected valid
// Build option: define ARB_TRACE_EN to print simulation-only grant/release lines.
module rr_port_arbiter
  import arb_pkg::*;
#(
  parameter int ID        = 0,
  parameter int PORTS     = 5,
  parameter int PORT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PORTS-1:0]     reqs_in,
  output logic [PORTS-1:0]     acks_in,
  output logic                 req_out,
  input  logic                 ack_out,
  output logic [PORT_BITS-1:0] selected,
  output logic                 active
);

  if (PORTS < 2 || PORTS > (1 << PORT_BITS) || ID < 0) begin : g_bad_cfg
    $error("rr_port_arbiter: PORTS must be 2..2**PORT_BITS and ID non-negative");
  end

  arb_state_t           state, state_n;
  logic [PORT_BITS-1:0] rr_ptr, rr_ptr_n;
  logic [PORT_BITS-1:0] selected_n;
  logic [PORTS-1:0]     acks_n;
  logic                 req_n;
  logic                 active_n;

  logic                 pick_any;
  logic [PORT_BITS-1:0] pick_winner;
  logic [PORTS-1:0]     sel_rot;
  logic                 sel_req;

  rr_pick #(
    .PORTS     (PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_pick (
    .reqs   (reqs_in),
    .ptr    (rr_ptr),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // Request bit of the granted RX port; shifting avoids a wide index select.
  assign sel_rot = reqs_in >> selected;
  assign sel_req = sel_rot[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      selected <= '0;
      acks_in  <= '0;
      req_out  <= 1'b0;
      active   <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      selected <= selected_n;
      acks_in  <= acks_n;
      req_out  <= req_n;
      active   <= active_n;
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    selected_n = selected;
    acks_n     = acks_in;
    req_n      = req_out;
    active_n   = active;
    case (state)
      IDLE: begin
        if (pick_any) begin
          selected_n = pick_winner;
          active_n   = 1'b1;
          req_n      = 1'b1;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        // Completion wins over a simultaneous withdrawal.
        if (ack_out) begin
          acks_n  = PORTS'(1) << selected;
          state_n = DONE;
        end else if (!sel_req) begin
          req_n   = 1'b0;
          state_n = RELEASE;
        end
      end
      DONE: begin
        if (!sel_req) begin
          req_n   = 1'b0;
          acks_n  = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_out) begin
          active_n = 1'b0;
          rr_ptr_n = PORT_BITS'(next_idx(int'(selected), PORTS));
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == IDLE && pick_any)
        $display("Arbiter %0d: grant RX %0d", ID, pick_winner);
      if (state == RELEASE && !ack_out)
        $display("Arbiter %0d: release RX %0d", ID, selected);
    end
  end
`else
`endif

endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb/tb_rr_port_arbiter.sv - randomized self-checking bench for rr_port_arbiter
module tb_rr_port_arbiter;

  localparam int PORTS     = 5;
  localparam int PORT_BITS = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [PORTS-1:0]     reqs_in;
  logic [PORTS-1:0]     acks_in;
  logic                 req_out;
  logic                 ack_out;
  logic [PORT_BITS-1:0] selected;
  logic                 active;

  int checks    = 0;
  int failures  = 0;
  int model_ptr = 0;
  int last_sel  = 0;
  int w;
  int fair_exp[6] = '{0, 1, 2, 3, 4, 0};

  always #5 clk = ~clk;

  rr_port_arbiter #(
    .ID        (3),
    .PORTS     (PORTS),
    .PORT_BITS (PORT_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reqs_in  (reqs_in),
    .acks_in  (acks_in),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .selected (selected),
    .active   (active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Winner = requesting port with the smallest forward distance from the pointer.
  function automatic int pick(input logic [PORTS-1:0] m, input int ptr);
    int best;
    int best_d;
    best   = -1;
    best_d = PORTS;
    for (int j = 0; j < PORTS; j++) begin
      int d;
      d = (j - ptr + PORTS) % PORTS;
      if (m[j] && d < best_d) begin
        best   = j;
        best_d = d;
      end
    end
    return best;
  endfunction

  function automatic logic [PORTS-1:0] others(input int keep);
    logic [PORTS-1:0] r;
    r = PORTS'($urandom);
    r[keep] = 1'b0;
    return r;
  endfunction

  task automatic do_reset;
    reset   = 1'b1;
    reqs_in = '0;
    ack_out = 1'b0;
    step;
    check("rst_active", active, 0);
    check("rst_req", req_out, 0);
    check("rst_acks", acks_in, 0);
    check("rst_sel", selected, 0);
    reset     = 1'b0;
    model_ptr = 0;
    last_sel  = 0;
  endtask

  // One full packet from IDLE; returns the DUT's granted index.
  task automatic packet(input logic [PORTS-1:0] mask, input bit withdraw, output int got_sel);
    int exp_w;
    int n;
    bit both;
    exp_w   = pick(mask, model_ptr);
    reqs_in = mask;
    ack_out = 1'b0;
    step;
    got_sel = int'(selected);
    check("grant_active", active, 1);
    check("grant_sel", selected, exp_w);
    check("grant_req", req_out, 1);
    check("grant_acks", acks_in, 0);
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      reqs_in = others(exp_w) | (PORTS'(1) << exp_w);
      step;
      check("busy_req", req_out, 1);
      check("busy_acks", acks_in, 0);
      check("busy_sel", selected, exp_w);
    end
    if (withdraw) begin
      reqs_in = others(exp_w);
      step;
      check("wd_req", req_out, 0);
      check("wd_acks", acks_in, 0);
      check("wd_active", active, 1);
      reqs_in = others(exp_w);
      step;
      check("wd_end_active", active, 0);
      check("wd_end_req", req_out, 0);
      check("wd_end_sel", selected, exp_w);
    end else begin
      both    = ($urandom_range(0, 3) == 0);
      ack_out = 1'b1;
      reqs_in = both ? others(exp_w) : (others(exp_w) | (PORTS'(1) << exp_w));
      step;
      check("done_acks", acks_in, 32'(PORTS'(1) << exp_w));
      check("done_req", req_out, 1);
      if (!both) begin
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
          reqs_in = others(exp_w) | (PORTS'(1) << exp_w);
          step;
          check("done_hold_acks", acks_in, 32'(PORTS'(1) << exp_w));
          check("done_hold_sel", selected, exp_w);
        end
        reqs_in = others(exp_w);
      end
      step;
      check("rel_req", req_out, 0);
      check("rel_acks", acks_in, 0);
      check("rel_active", active, 1);
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        reqs_in = others(exp_w);
        step;
        check("rel_hold_active", active, 1);
      end
      ack_out = 1'b0;
      step;
      check("end_active", active, 0);
      check("end_req", req_out, 0);
      check("end_sel", selected, exp_w);
    end
    reqs_in   = '0;
    model_ptr = (exp_w + 1) % PORTS;
    last_sel  = exp_w;
  endtask

  initial begin
    do_reset;
    step;
    check("idle_active", active, 0);

    packet(5'b00100, 1'b0, w);
    check("default_sel", w, 2);

    do_reset;
    for (int i = 0; i < 6; i++) begin
      packet(5'b11111, 1'b0, w);
      check("fair_order", w, fair_exp[i]);
    end

    packet(5'b10000, 1'b0, w);
    check("wrap_pre", w, 4);
    packet(5'b00011, 1'b0, w);
    check("wrap_sel", w, 0);

    packet(5'b00010, 1'b0, w);
    check("hold_sel", w, 1);
    packet(5'b01000, 1'b1, w);
    check("withdraw_sel", w, 3);

    reqs_in = 5'b00100;
    step;
    ack_out = 1'b1;
    step;
    check("pre_rst_acks", acks_in, 5'b00100);
    reset = 1'b1;
    step;
    check("mid_rst_active", active, 0);
    check("mid_rst_req", req_out, 0);
    check("mid_rst_acks", acks_in, 0);
    check("mid_rst_sel", selected, 0);
    reset     = 1'b0;
    ack_out   = 1'b0;
    reqs_in   = '0;
    model_ptr = 0;
    step;
    packet(5'b11111, 1'b0, w);
    check("post_rst_sel", w, 0);

    for (int t = 0; t < 40; t++) begin
      logic [PORTS-1:0] m;
      int gap;
      m = PORTS'($urandom_range(1, (1 << PORTS) - 1));
      packet(m, $urandom_range(0, 2) == 0, w);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step;
        check("gap_active", active, 0);
        check("gap_sel", selected, last_sel);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
